// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU control unit: funct codes, main-control op
// classes, ALU select codes and the sequencer state encoding.
package alu_ctrl_pkg;

  // R-type funct field values (instruction[5:0])
  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_MULT = 6'h18;
  localparam logic [5:0] F_DIV  = 6'h1A;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  // Main-control op classes (low three bits of alu_op)
  localparam logic [2:0] AOP_RTYPE = 3'd0;
  localparam logic [2:0] AOP_ADD   = 3'd1;
  localparam logic [2:0] AOP_SUB   = 3'd2;
  localparam logic [2:0] AOP_AND   = 3'd3;
  localparam logic [2:0] AOP_OR    = 3'd4;
  localparam logic [2:0] AOP_SLT   = 3'd5;
  localparam logic [2:0] AOP_XOR   = 3'd6;
  localparam logic [2:0] AOP_ILL   = 3'd7;

  // ALU select codes
  localparam logic [3:0] SEL_ADD  = 4'd0;
  localparam logic [3:0] SEL_SUB  = 4'd1;
  localparam logic [3:0] SEL_AND  = 4'd2;
  localparam logic [3:0] SEL_OR   = 4'd3;
  localparam logic [3:0] SEL_SLL  = 4'd4;
  localparam logic [3:0] SEL_SRL  = 4'd5;
  localparam logic [3:0] SEL_SLT  = 4'd6;
  localparam logic [3:0] SEL_XOR  = 4'd7;
  localparam logic [3:0] SEL_NOR  = 4'd8;
  localparam logic [3:0] SEL_SRA  = 4'd9;
  localparam logic [3:0] SEL_SLTU = 4'd10;
  localparam logic [3:0] SEL_MULT = 4'd11;
  localparam logic [3:0] SEL_DIV  = 4'd12;

  // Sequencer states
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of (alu_op, funct) into an ALU select code plus
// illegal and multi-cycle flags. Every input combination yields a defined
// result; anything unrecognised becomes select=0 with illegal set.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int SEL_W   = 4,
  parameter int ALUOP_W = 3
) (
  input  logic [5:0]         funct,
  input  logic [ALUOP_W-1:0] alu_op,
  output logic [SEL_W-1:0]   sel,
  output logic               illegal,
  output logic               multi
);

  logic       upper_nz;
  logic [2:0] op3;
  logic [3:0] code;
  logic       bad;
  logic       mul;

  // Any set bit above the three class bits makes the op illegal
  generate
    if (ALUOP_W > 3) begin : g_wide_op
      assign upper_nz = |alu_op[ALUOP_W-1:3];
    end else begin : g_narrow_op
      assign upper_nz = 1'b0;
    end
  endgenerate

  assign op3 = alu_op[2:0];

  // Class decode, falling through to the funct table for R-type
  always_comb begin
    code = SEL_ADD;
    bad  = 1'b0;
    mul  = 1'b0;
    case (op3)
      AOP_RTYPE: begin
        case (funct)
          F_ADD, F_ADDU: code = SEL_ADD;
          F_SUB, F_SUBU: code = SEL_SUB;
          F_AND:         code = SEL_AND;
          F_OR:          code = SEL_OR;
          F_SLL:         code = SEL_SLL;
          F_SRL:         code = SEL_SRL;
          F_SLT:         code = SEL_SLT;
          F_XOR:         code = SEL_XOR;
          F_NOR:         code = SEL_NOR;
          F_SRA:         code = SEL_SRA;
          F_SLTU:        code = SEL_SLTU;
          F_MULT: begin
            code = SEL_MULT;
            mul  = 1'b1;
          end
          F_DIV: begin
            code = SEL_DIV;
            mul  = 1'b1;
          end
          default:       bad  = 1'b1;
        endcase
      end
      AOP_ADD: code = SEL_ADD;
      AOP_SUB: code = SEL_SUB;
      AOP_AND: code = SEL_AND;
      AOP_OR:  code = SEL_OR;
      AOP_SLT: code = SEL_SLT;
      AOP_XOR: code = SEL_XOR;
      AOP_ILL: bad  = 1'b1;
      default: bad  = 1'b1;
    endcase
    if (upper_nz) begin
      bad = 1'b1;
    end
    // An illegal op never reports a real select or a multi-cycle request
    if (bad) begin
      code = SEL_ADD;
      mul  = 1'b0;
    end
  end

  assign sel     = SEL_W'(code);
  assign illegal = bad;
  assign multi   = mul;

endmodule

// File: rtl/alu_ctrl_seq.sv
// ALU control unit with valid/ready handshake. Registers the decode result
// on each accept and sequences multi-cycle MULT/DIV, holding off issue for
// the exact number of busy cycles of the multiply/divide unit.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int SEL_W      = 4,
  parameter int ALUOP_W    = 3,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 8,
  parameter int CNT_W      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [5:0]         funct,
  input  logic [ALUOP_W-1:0] alu_op,
  output logic               out_valid,
  output logic [SEL_W-1:0]   select,
  output logic               illegal,
  output logic               multi,
  output logic               busy,
  output logic               done
);

  // Elaboration-time parameter bounds
  generate
    if (SEL_W < 4) begin : g_bad_sel_w
      $error("alu_ctrl_seq: SEL_W must be at least 4");
    end
    if (ALUOP_W < 3) begin : g_bad_aluop_w
      $error("alu_ctrl_seq: ALUOP_W must be at least 3");
    end
    if (MUL_CYCLES < 1 || DIV_CYCLES < 1) begin : g_bad_cycles
      $error("alu_ctrl_seq: MUL_CYCLES and DIV_CYCLES must be at least 1");
    end
    if ((1 << CNT_W) < MUL_CYCLES || (1 << CNT_W) < DIV_CYCLES) begin : g_bad_cnt_w
      $error("alu_ctrl_seq: CNT_W too narrow for the busy counter");
    end
  endgenerate

  // Counter load values: cnt counts down to zero, so N busy cycles load N-1
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  logic [SEL_W-1:0] dec_sel;
  logic             dec_illegal;
  logic             dec_multi;
  logic             dec_is_div;
  logic             accept;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [SEL_W-1:0] select_q;
  logic             illegal_q;
  logic             multi_q;
  logic             out_valid_q;
  logic             done_q;

  alu_ctrl_decode #(
    .SEL_W   (SEL_W),
    .ALUOP_W (ALUOP_W)
  ) u_decode (
    .funct   (funct),
    .alu_op  (alu_op),
    .sel     (dec_sel),
    .illegal (dec_illegal),
    .multi   (dec_multi)
  );

  assign dec_is_div = (dec_sel == SEL_W'(SEL_DIV));
  assign in_ready   = (state_q == IDLE);
  assign accept     = in_valid && in_ready && !flush;

  // Result registers, handshake pulses and the IDLE/BUSY sequencer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      select_q    <= '0;
      illegal_q   <= 1'b0;
      multi_q     <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      out_valid_q <= accept;
      done_q      <= 1'b0;
      if (accept) begin
        select_q  <= dec_sel;
        illegal_q <= dec_illegal;
        multi_q   <= dec_multi;
      end
      case (state_q)
        IDLE: begin
          if (accept && dec_multi) begin
            state_q <= BUSY;
            cnt_q   <= dec_is_div ? DIV_LOAD : MUL_LOAD;
          end
        end
        BUSY: begin
          // flush aborts silently, even on the final busy cycle
          if (flush) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == '0) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign select    = select_q;
  assign illegal   = illegal_q;
  assign multi     = multi_q;
  assign busy      = (state_q == BUSY);
  assign done      = done_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: decoded results are predicted by a
// table model when an op is driven, queued, and compared when out_valid
// presents them.
module tb_alu_ctrl_seq;

  localparam int SEL_W      = 4;
  localparam int ALUOP_W    = 3;
  localparam int MUL_CYCLES = 4;
  localparam int DIV_CYCLES = 8;
  localparam int CNT_W      = 4;

  // {select, illegal, multi}
  typedef logic [SEL_W+1:0] exp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [5:0]         funct;
  logic [ALUOP_W-1:0] alu_op;
  logic               out_valid;
  logic [SEL_W-1:0]   select;
  logic               illegal;
  logic               multi;
  logic               busy;
  logic               done;

  exp_t exp_q[$];
  exp_t e;
  exp_t last;
  int   n_pass  = 0;
  int   n_total = 0;

  // {out_valid, select, illegal, multi, busy, in_ready, done}
  logic [SEL_W+5:0] obs;
  logic [SEL_W+5:0] x;
  assign obs = {out_valid, select, illegal, multi, busy, in_ready, done};

  alu_ctrl_seq #(
    .SEL_W      (SEL_W),
    .ALUOP_W    (ALUOP_W),
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .funct     (funct),
    .alu_op    (alu_op),
    .out_valid (out_valid),
    .select    (select),
    .illegal   (illegal),
    .multi     (multi),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference decode table
  function automatic exp_t model(input logic [5:0] f, input logic [2:0] op);
    logic [3:0] s;
    logic       il;
    logic       m;
    s = 4'd0; il = 1'b0; m = 1'b0;
    case (op)
      3'd0: begin
        case (f)
          6'h20, 6'h21: s = 4'd0;
          6'h22, 6'h23: s = 4'd1;
          6'h24: s = 4'd2;
          6'h25: s = 4'd3;
          6'h00: s = 4'd4;
          6'h02: s = 4'd5;
          6'h2A: s = 4'd6;
          6'h26: s = 4'd7;
          6'h27: s = 4'd8;
          6'h03: s = 4'd9;
          6'h2B: s = 4'd10;
          6'h18: begin s = 4'd11; m = 1'b1; end
          6'h1A: begin s = 4'd12; m = 1'b1; end
          default: il = 1'b1;
        endcase
      end
      3'd1: s = 4'd0;
      3'd2: s = 4'd1;
      3'd3: s = 4'd2;
      3'd4: s = 4'd3;
      3'd5: s = 4'd6;
      3'd6: s = 4'd7;
      default: il = 1'b1;
    endcase
    return {s, il, m};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; alu_op = 3'd0; funct = 6'h22;
    for (int i = 0; i < 2; i++) begin
      step();
      x = {1'b0, exp_t'(0), 3'b010};
      n_total++;
      if (obs !== x) $display("FAIL reset[%0d]: got %h want %h", i, obs, x);
      else n_pass++;
    end
    rst = 1'b0;
    exp_q.push_back(model(funct, alu_op));
    step();
    e = exp_q.pop_front(); last = e;
    x = {1'b1, e, 3'b010};
    n_total++;
    if (obs !== x) $display("FAIL reset_release_accept: got %h want %h", obs, x);
    else n_pass++;
    in_valid = 1'b0;
    step();
    x = {1'b0, last, 3'b010};
    n_total++;
    if (obs !== x) $display("FAIL reset_idle_hold: got %h want %h", obs, x);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [5:0] fl [4] = '{6'h20, 6'h22, 6'h2A, 6'h27};
    alu_op = 3'd0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      funct = fl[i];
      exp_q.push_back(model(funct, alu_op));
      step();
      e = exp_q.pop_front(); last = e;
      x = {1'b1, e, 3'b010};
      n_total++;
      if (obs !== x) $display("FAIL b2b[%0d]: got %h want %h", i, obs, x);
      else n_pass++;
    end
    in_valid = 1'b0;
    step();
    x = {1'b0, 4'd8, 2'b00, 3'b010};
    n_total++;
    if (obs !== x) $display("FAIL b2b_hold_nor: got %h want %h", obs, x);
    else n_pass++;
  endtask

  task automatic test_decode();
    logic [5:0] fl [9] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h00, 6'h02, 6'h03, 6'h26, 6'h2B};
    int n;
    in_valid = 1'b1;
    n = 0;
    for (int i = 0; i < 9 + 6 + 10; i++) begin
      if (i < 9) begin
        alu_op = 3'd0; funct = fl[i];
      end else if (i < 15) begin
        alu_op = 3'(i - 8); funct = 6'($urandom_range(0, 63));
      end else begin
        alu_op = 3'd0;
        funct = 6'($urandom_range(0, 63));
        if (funct == 6'h18 || funct == 6'h1A) funct = 6'h3E;
      end
      exp_q.push_back(model(funct, alu_op));
      step();
      e = exp_q.pop_front(); last = e;
      x = {1'b1, e, 3'b010};
      n_total++;
      if (obs !== x) $display("FAIL decode[%0d] op=%0d funct=%h: got %h want %h", i, alu_op, funct, obs, x);
      else n_pass++;
      n++;
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_illegal();
    logic [2:0] ol [4] = '{3'd0, 3'd7, 3'd7, 3'd0};
    logic [5:0] fl [4] = '{6'h3F, 6'h20, 6'h18, 6'h01};
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      alu_op = ol[i]; funct = fl[i];
      exp_q.push_back(model(funct, alu_op));
      step();
      e = exp_q.pop_front(); last = e;
      x = {1'b1, 4'd0, 2'b10, 3'b010};
      n_total++;
      if (obs !== x || e !== x[SEL_W+4:3]) $display("FAIL illegal[%0d]: got %h want %h", i, obs, x);
      else n_pass++;
    end
    // flush in IDLE blocks acceptance and leaves the result untouched
    alu_op = 3'd1; funct = 6'h00; flush = 1'b1;
    step();
    x = {1'b0, last, 3'b010};
    n_total++;
    if (obs !== x) $display("FAIL flush_idle: got %h want %h", obs, x);
    else n_pass++;
    flush = 1'b0; in_valid = 1'b0;
    step();
  endtask

  task automatic test_multicycle(input logic [5:0] f, input int cycles, input logic hold_next);
    int   lowcnt;
    logic sawov;
    alu_op = 3'd0; funct = f; in_valid = 1'b1;
    exp_q.push_back(model(funct, alu_op));
    step();
    e = exp_q.pop_front(); last = e;
    x = {1'b1, e, 3'b100};
    n_total++;
    if (obs !== x) $display("FAIL mc_accept f=%h: got %h want %h", f, obs, x);
    else n_pass++;
    funct = 6'h25;
    in_valid = hold_next;
    lowcnt = 1; sawov = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (in_ready !== 1'b0) break;
      lowcnt++;
      if (out_valid !== 1'b0) sawov = 1'b1;
    end
    n_total++;
    if (lowcnt != cycles || sawov) $display("FAIL mc_ready_low f=%h: got %0d cycles ov=%b want %0d ov=0", f, lowcnt, sawov, cycles);
    else n_pass++;
    x = {1'b0, last, 3'b011};
    n_total++;
    if (obs !== x) $display("FAIL mc_done f=%h: got %h want %h", f, obs, x);
    else n_pass++;
    if (hold_next) begin
      exp_q.push_back(model(funct, alu_op));
      step();
      e = exp_q.pop_front(); last = e;
      x = {1'b1, e, 3'b010};
      n_total++;
      if (obs !== x) $display("FAIL mc_held_accept: got %h want %h", obs, x);
      else n_pass++;
      in_valid = 1'b0;
    end
    step();
    x = {1'b0, last, 3'b010};
    n_total++;
    if (obs !== x) $display("FAIL mc_after f=%h: got %h want %h", f, obs, x);
    else n_pass++;
  endtask

  task automatic test_flush_busy(input logic [5:0] f, input int flush_cycle);
    alu_op = 3'd0; funct = f; in_valid = 1'b1;
    exp_q.push_back(model(funct, alu_op));
    step();
    e = exp_q.pop_front(); last = e;
    in_valid = 1'b0;
    for (int k = 1; k < flush_cycle; k++) step();
    x = {1'b0, last, 3'b100};
    n_total++;
    if (obs !== x) $display("FAIL flush_pre f=%h: got %h want %h", f, obs, x);
    else n_pass++;
    flush = 1'b1;
    step();
    flush = 1'b0;
    x = {1'b0, last, 3'b010};
    n_total++;
    if (obs !== x) $display("FAIL flush_busy f=%h: got %h want %h", f, obs, x);
    else n_pass++;
    step();
    n_total++;
    if (obs !== x) $display("FAIL flush_no_done f=%h: got %h want %h", f, obs, x);
    else n_pass++;
    alu_op = 3'd0; funct = 6'h20; in_valid = 1'b1;
    exp_q.push_back(model(funct, alu_op));
    step();
    e = exp_q.pop_front(); last = e;
    x = {1'b1, e, 3'b010};
    n_total++;
    if (obs !== x) $display("FAIL flush_then_add: got %h want %h", obs, x);
    else n_pass++;
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_rst_busy();
    alu_op = 3'd0; funct = 6'h1A; in_valid = 1'b1;
    exp_q.push_back(model(funct, alu_op));
    step();
    e = exp_q.pop_front(); last = e;
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    x = {1'b0, exp_t'(0), 3'b010};
    n_total++;
    if (obs !== x) $display("FAIL rst_busy: got %h want %h", obs, x);
    else n_pass++;
    step();
    n_total++;
    if (obs !== x) $display("FAIL rst_busy_no_done: got %h want %h", obs, x);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; funct = '0; alu_op = '0;
    test_reset();
    test_back_to_back();
    test_decode();
    test_illegal();
    test_multicycle(6'h18, MUL_CYCLES, 1'b1);
    test_multicycle(6'h1A, DIV_CYCLES, 1'b0);
    test_flush_busy(6'h1A, 3);
    test_flush_busy(6'h18, MUL_CYCLES);
    test_rst_busy();
    n_total++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
- Second-generation ALU control unit for the MIPS datapath.
- Decodes the main-control alu_op and the R-type funct field into an ALU select code, with an explicit illegal flag. Undecodable ops never produce X.
- Adds a valid/ready handshake and a sequencer for multi-cycle MULT/DIV, which holds off issue while the multiply/divide unit is busy.
- Sits between the ID-stage control decoder and the ALU/muldiv unit.

Parameters:
- SEL_W, 4, width of the select output. Must be ≥4.
- ALUOP_W, 3, width of alu_op.
- MUL_CYCLES, 4, number of BUSY cycles for MULT. Must be ≥1.
- DIV_CYCLES, 8, number of BUSY cycles for DIV. Must be ≥1.
- CNT_W, 4, width of the busy counter. Must satisfy 2^CNT_W ≥ max(MUL_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  abort the current op; also blocks acceptance this cycle.
- in_valid  in  1  funct/alu_op are valid.
- in_ready  out  1  block can accept; equals (state==IDLE).
- funct  in  6  instruction[5:0].
- alu_op  in  ALUOP_W  op class from main control.
- out_valid  out  1  one-cycle pulse: select/illegal/multi are updated.
- select  out  SEL_W  ALU operation code; held between accepts.
- illegal  out  1  decoded op was unrecognised; held.
- multi  out  1  decoded op is MULT or DIV; held.
- busy  out  1  state==BUSY.
- done  out  1  one-cycle pulse: multi-cycle op completed.

Behaviour:
- Reset values: select=0, illegal=0, multi=0, out_valid=0, done=0, state=IDLE, cnt=0. rst overrides all inputs, including mid-BUSY (abort, no done pulse).
- alu_op decode:
  - 0 = R-type (decode funct).
  - 1 = ADD, 2 = SUB, 3 = AND, 4 = OR, 5 = SLT, 6 = XOR.
  - 7 = illegal.
- funct decode (select code in parentheses):
  - 0x20/0x21 ADD(0), 0x22/0x23 SUB(1), 0x24 AND(2), 0x25 OR(3)
  - 0x00 SLL(4), 0x02 SRL(5), 0x2A SLT(6), 0x26 XOR(7), 0x27 NOR(8)
  - 0x03 SRA(9), 0x2B SLTU(10), 0x18 MULT(11), 0x1A DIV(12)
  - Any other funct: select=0, illegal=1.
- Accept condition: in_valid && in_ready && !flush.
- On the accepting edge (latency 1 cycle): select, illegal and multi are registered; out_valid=1 for exactly that following cycle.
- out_valid=0 in every cycle with no accept. select/illegal/multi hold their last value.
- FSM IDLE:
  - Accept of MULT → BUSY, cnt=MUL_CYCLES-1.
  - Accept of DIV → BUSY, cnt=DIV_CYCLES-1.
  - Any other accept stays in IDLE, so back-to-back single-cycle ops run at 1 per clock.
- FSM BUSY:
  - in_ready=0; input is ignored.
  - If cnt≠0: cnt decrements.
  - If cnt==0: done=1 on the next cycle and state→IDLE. in_ready therefore is low for exactly MUL_CYCLES/DIV_CYCLES cycles.
- flush:
  - In BUSY: state→IDLE, cnt=0, no done pulse. select/illegal/multi unchanged.
  - In IDLE: no accept, no out_valid, registered outputs unchanged.
  - flush and cnt==0 in the same cycle: flush wins, no done.
- An illegal op never enters BUSY, even when alu_op=0.
- Ops wider than ALUOP_W bits decode on the low 3 bits. Upper bits must be 0, otherwise the op is illegal.
- The counter never wraps. Parameter bounds are checked by elaboration-time assertion.

Decomposition:
- Shared package alu_ctrl_pkg holds:
  - funct constants (F_ADD, F_SUB, …, F_MULT, F_DIV)
  - alu_op class constants (AOP_RTYPE … AOP_XOR)
  - select code constants (SEL_ADD=0 … SEL_DIV=12)
  - FSM state encoding (IDLE, BUSY)
- One natural combinational sub-module, alu_ctrl_decode: inputs (funct, alu_op); outputs (sel, illegal, multi). alu_ctrl_seq adds the registers, FSM and counter around it.

Test Plan:
- rst=1 for 2 cycles with in_valid=1 → all outputs 0, in_ready=1. Release rst → first accept next edge.
- Back-to-back alu_op=0 with funct 0x20, 0x22, 0x2A, 0x27 on consecutive cycles → out_valid high for 4 cycles; select=0, 1, 6, 8; in_ready stays 1.
- alu_op=0, funct=0x18 (MUL_CYCLES=4) → out_valid pulse with select=11, multi=1. in_ready low exactly 4 cycles, then done pulses 1 cycle, then in_ready=1. A held second op is accepted only after that.
- alu_op=0, funct=0x3F; then alu_op=7 → each gives select=0, illegal=1, out_valid pulse, no BUSY.
- DIV accepted, flush asserted on the 3rd BUSY cycle → IDLE next cycle, no done pulse. A new ADD with flush=0 is then accepted.
- DIV accepted, rst on the 2nd BUSY cycle → all outputs at reset values next cycle, no done.
